// File: rtl/execute_mdu.sv
// execute_mdu: pipeline execute stage.
//   Operand forwarding, a small ALU and a multi-cycle multiply/divide unit that
//   owns the architectural HI/LO registers.
// Ports:
//   clk, reset_n                     clock (rising edge), async active-low reset
//   validE, alusrcE, regdstE         instruction valid, B-source select, dest select
//   alucontrolE[2:0], mdopE[2:0]     ALU function, MDU operation
//   rd1E, rd2E, signE                register operands, sign-extended immediate
//   aluoutM, resultW                 forwarding sources from MEM / WB
//   forwardaE, forwardbE             forwarding selects for A / B
//   rdE, rtE                         destination register candidates
//   writeregE, writedataE, aluoutE   selected dest, forwarded B, ALU/HI/LO result
//   stallE                           hold EX and upstream while MDU busy
//   hi, lo                           architectural HI/LO registers
//
// MDU FSM
//   state  | meaning
//   S_IDLE | no operation pending, MDU ops may issue, MFHI/MFLO read HI/LO
//   S_MUL  | product pending, HI/LO written when the counter reaches zero
//   S_DIV  | one quotient bit per cycle, final cycle applies signs and writes HI/LO
module execute_mdu #(
    parameter int WIDTH      = 32,
    parameter int REGW       = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             validE,
    input  logic             alusrcE,
    input  logic             regdstE,
    input  logic [2:0]       alucontrolE,
    input  logic [2:0]       mdopE,
    input  logic [WIDTH-1:0] rd1E,
    input  logic [WIDTH-1:0] rd2E,
    input  logic [WIDTH-1:0] signE,
    input  logic [WIDTH-1:0] aluoutM,
    input  logic [WIDTH-1:0] resultW,
    input  logic [1:0]       forwardaE,
    input  logic [1:0]       forwardbE,
    input  logic [REGW-1:0]  rdE,
    input  logic [REGW-1:0]  rtE,
    output logic [REGW-1:0]  writeregE,
    output logic [WIDTH-1:0] writedataE,
    output logic [WIDTH-1:0] aluoutE,
    output logic             stallE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] srca, srcb_fwd, srcb, alu_res;
    logic [2:0]       mdop;
    logic             issue, issue_mul, issue_sgn;
    logic [WIDTH-1:0] abs_a, abs_b;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               ge;
    logic [WIDTH-1:0]   quo_step, rem_step;
    logic               q_neg, r_neg;
    logic [WIDTH-1:0]   div_lo, div_hi;

    // Forwarding and ALU
    always_comb begin
        case (forwardaE)
            2'b01:   srca = resultW;
            2'b10:   srca = aluoutM;
            default: srca = rd1E;
        endcase
        case (forwardbE)
            2'b01:   srcb_fwd = resultW;
            2'b10:   srcb_fwd = aluoutM;
            default: srcb_fwd = rd2E;
        endcase
        srcb = alusrcE ? signE : srcb_fwd;
    end

    always_comb begin
        case (alucontrolE)
            3'b010:  alu_res = srca + srcb;
            3'b110:  alu_res = srca - srcb;
            3'b000:  alu_res = srca & srcb;
            3'b001:  alu_res = srca | srcb;
            3'b111:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: alu_res = '0;
        endcase
    end

    // Encoding 111 is reserved and behaves as "no MDU operation".
    assign mdop = (mdopE == 3'b111) ? OP_NONE : mdopE;

    always_comb begin
        case (mdop)
            OP_MFHI: aluoutE = hi_q;
            OP_MFLO: aluoutE = lo_q;
            default: aluoutE = alu_res;
        endcase
    end

    assign writeregE  = regdstE ? rdE : rtE;
    assign writedataE = srcb_fwd;

    assign stallE    = validE && (mdop != OP_NONE) && (state_q != S_IDLE);
    assign issue     = validE && (state_q == S_IDLE) &&
                       (mdop == OP_MULT || mdop == OP_MULTU || mdop == OP_DIV || mdop == OP_DIVU);
    assign issue_mul = (mdop == OP_MULT) || (mdop == OP_MULTU);
    assign issue_sgn = (mdop == OP_MULT) || (mdop == OP_DIV);
    assign abs_a     = (issue_sgn && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
    assign abs_b     = (issue_sgn && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;

    // Sign-extending to 2*WIDTH makes the truncated product the signed result.
    always_comb begin
        if (sgn_q)
            prod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        else
            prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    end

    // Restoring divide step on magnitudes; quo_q starts as |dividend| and is
    // shifted out into the partial remainder while quotient bits shift in.
    always_comb begin
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, dvs_q});
        rem_diff = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        rem_step = rem_diff[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ge};
    end

    // Quotient truncates toward zero, remainder takes the dividend's sign.
    // The overflow case falls out naturally: |MIN| / 1 = MIN, both signs negative.
    always_comb begin
        q_neg = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg = sgn_q && a_q[WIDTH-1];
        if (b_q == '0) begin
            div_lo = '1;
            div_hi = a_q;
        end else begin
            div_lo = q_neg ? (~quo_q + 1'b1) : quo_q;
            div_hi = r_neg ? (~rem_q + 1'b1) : rem_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    a_d   = srca;
                    b_d   = srcb;
                    sgn_d = issue_sgn;
                    if (issue_mul) begin
                        state_d = S_MUL;
                        cnt_d   = CW'(MUL_CYCLES - 1);
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = CW'(WIDTH);
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        rem_d   = '0;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    hi_d    = div_hi;
                    lo_d    = div_lo;
                    state_d = S_IDLE;
                end else begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
